// File: rtl/skel_pkg.sv
// Shared types and helpers for the skeletonization front end: sequencer states,
// pixel width and frame-size arithmetic.
package skel_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    DUMP  = 3'd4
  } seq_state_t;

  function automatic int last_addr(input int n);
    return n * n - 1;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Frame store: one synchronous write port, two asynchronous read ports
// (A for the bus/dump pointer, B for the result-compare address).
module frame_ram
  import skel_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    ra_addr,
  output logic [PIX_W-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  output logic [PIX_W-1:0] rb_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[IW-1:0]] <= wdata;
  end

  assign ra_data = mem[ra_addr[IW-1:0]];
  assign rb_data = mem[rb_addr[IW-1:0]];

  // Address bits above the array index never reach a live entry.
  if (AW > IW) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^{waddr[AW-1:IW], ra_addr[AW-1:IW], rb_addr[AW-1:IW]};
  end

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Holds one N x N frame, sweeps it over the shared kernel bus (write then read),
// folds collector results back in until the frame settles, then streams it out.
module pixel_frame_sequencer
  import skel_pkg::*;
#(
  parameter int N        = 8,
  parameter int bitSize  = 6,
  parameter int MAX_ITER = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  input  logic [PIX_W-1:0]   load_data,
  output logic               load_ready,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [7:0]         iterations,
  output logic               k_we,
  output logic [bitSize:0]   k_addr,
  output logic [PIX_W-1:0]   k_data,
  input  logic               res_valid,
  input  logic [bitSize:0]   res_addr,
  input  logic [PIX_W-1:0]   res_data,
  output logic               out_valid,
  output logic [bitSize:0]   out_addr,
  output logic [PIX_W-1:0]   out_data,
  input  logic               out_ready
);

  localparam int            AW    = bitSize + 1;
  localparam int            DEPTH = N * N;
  localparam logic [AW-1:0] LAST  = AW'(last_addr(N));
  localparam logic [AW-1:0] ONE   = AW'(1);
  localparam logic [7:0]    MAX_B = 8'(MAX_ITER);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  seq_state_t       state_q, state_d;
  logic [AW-1:0]    ld_ptr_q, ld_ptr_d;
  logic             frame_loaded_q, frame_loaded_d;
  logic             phase_q, phase_d;
  logic             changed_q, changed_d;
  logic [7:0]       iter_q, iter_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_ready_q, load_ready_d;
  logic             k_we_q, k_we_d;
  logic [AW-1:0]    k_addr_q, k_addr_d;
  logic [PIX_W-1:0] k_data_q, k_data_d;
  logic             out_valid_q, out_valid_d;
  logic [AW-1:0]    out_addr_q, out_addr_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;

  logic             k_sel, o_sel;
  logic             ld_we, res_we;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [PIX_W-1:0] ram_wdata;
  logic [AW-1:0]    ra_addr;
  logic [PIX_W-1:0] ra_data, rb_data;

  frame_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .ra_addr (ra_addr),
    .ra_data (ra_data),
    .rb_addr (res_addr),
    .rb_data (rb_data)
  );

  always_comb begin
    state_d        = state_q;
    ld_ptr_d       = ld_ptr_q;
    frame_loaded_d = frame_loaded_q;
    phase_d        = phase_q;
    changed_d      = changed_q;
    iter_d         = iter_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    load_ready_d   = 1'b0;
    k_we_d         = 1'b0;
    k_addr_d       = '0;
    k_sel          = 1'b0;
    out_valid_d    = 1'b0;
    out_addr_d     = '0;
    o_sel          = 1'b0;
    ld_we          = 1'b0;
    res_we         = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready_d = 1'b1;
        if (load_ready_q && load_valid) begin
          ld_we = 1'b1;
          if (ld_ptr_q == LAST) begin
            ld_ptr_d       = '0;
            frame_loaded_d = 1'b1;
          end else begin
            ld_ptr_d = ld_ptr_q + ONE;
          end
        end
        if (start && frame_loaded_q) begin
          state_d      = WRITE;
          iter_d       = 8'd0;
          changed_d    = 1'b0;
          busy_d       = 1'b1;
          load_ready_d = 1'b0;
          k_we_d       = 1'b1;
          k_sel        = 1'b1;
          phase_d      = 1'b0;
        end
      end

      WRITE: begin
        k_we_d   = 1'b1;
        k_sel    = 1'b1;
        k_addr_d = k_addr_q;
        phase_d  = ~phase_q;
        if (phase_q) begin
          if (k_addr_q == LAST) begin
            state_d  = READ;
            k_we_d   = 1'b0;
            k_addr_d = '0;
          end else begin
            k_addr_d = k_addr_q + ONE;
          end
        end
      end

      READ: begin
        k_sel    = 1'b1;
        k_addr_d = k_addr_q;
        phase_d  = ~phase_q;
        if (res_valid) begin
          res_we = 1'b1;
          if (res_data != rb_data) changed_d = 1'b1;
        end
        if (phase_q) begin
          if (k_addr_q == LAST) begin
            state_d  = CHECK;
            k_sel    = 1'b0;
            k_addr_d = '0;
          end else begin
            k_addr_d = k_addr_q + ONE;
          end
        end
      end

      CHECK: begin
        iter_d = sat_inc(iter_q);
        if (!changed_q || iter_d == MAX_B) begin
          state_d     = DUMP;
          out_valid_d = 1'b1;
          o_sel       = 1'b1;
        end else begin
          state_d   = WRITE;
          changed_d = 1'b0;
          k_we_d    = 1'b1;
          k_sel     = 1'b1;
          phase_d   = 1'b0;
        end
      end

      DUMP: begin
        out_valid_d = 1'b1;
        o_sel       = 1'b1;
        out_addr_d  = out_addr_q;
        if (out_valid_q && out_ready) begin
          if (out_addr_q == LAST) begin
            state_d        = IDLE;
            out_valid_d    = 1'b0;
            out_addr_d     = '0;
            o_sel          = 1'b0;
            done_d         = 1'b1;
            busy_d         = 1'b0;
            frame_loaded_d = 1'b0;
            load_ready_d   = 1'b1;
          end else begin
            out_addr_d = out_addr_q + ONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Port A looks ahead to the next pointer so data registers alongside its address.
  assign ra_addr = k_sel ? k_addr_d : out_addr_d;

  always_comb begin
    k_data_d   = '0;
    out_data_d = '0;
    if (k_sel) k_data_d = ra_data;
    if (o_sel) out_data_d = ra_data;
  end

  assign ram_we    = ld_we | res_we;
  assign ram_waddr = ld_we ? ld_ptr_q  : res_addr;
  assign ram_wdata = ld_we ? load_data : res_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ld_ptr_q       <= '0;
      frame_loaded_q <= 1'b0;
      phase_q        <= 1'b0;
      changed_q      <= 1'b0;
      iter_q         <= 8'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      load_ready_q   <= 1'b0;
      k_we_q         <= 1'b0;
      k_addr_q       <= '0;
      k_data_q       <= '0;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      ld_ptr_q       <= ld_ptr_d;
      frame_loaded_q <= frame_loaded_d;
      phase_q        <= phase_d;
      changed_q      <= changed_d;
      iter_q         <= iter_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      load_ready_q   <= load_ready_d;
      k_we_q         <= k_we_d;
      k_addr_q       <= k_addr_d;
      k_data_q       <= k_data_d;
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_data_q     <= out_data_d;
    end
  end

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign iterations = iter_q;
  assign k_we       = k_we_q;
  assign k_addr     = k_addr_q;
  assign k_data     = k_data_q;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;

endmodule

// File: doc/pixel_frame_sequencer.md
# pixel_frame_sequencer

Upstream stage of the skeletonization datapath. Holds one N×N 8-bit frame and drives the shared pixel bus (`k_we`, `k_addr`, `k_data`) that every kernelRam instance snoops. Each iteration is a write sweep followed by a read sweep, during which per-pixel results from the collector are written back. The block repeats this until the frame stops changing or MAX_ITER is reached, then streams the final frame out.

## Interface
- N, 8, image side length; frame holds N*N pixels
- bitSize, 6, address MSB index; address width is bitSize+1 and must hold N*N-1
- MAX_ITER, 16, iteration cap, range 1..255
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_valid  in  1  input pixel beat valid, raster order
- load_data  in  8  input pixel
- load_ready  out  1  frame accepting input pixels
- start  in  1  begin skeletonization; single-cycle pulse or level
- busy  out  1  high from start acceptance until the cycle of the done pulse
- done  out  1  one-cycle pulse after the last output beat
- iterations  out  8  iterations executed in the current/last run
- k_we  out  1  kernel bus write phase (1) / read phase (0)
- k_addr  out  bitSize+1  kernel bus pixel address
- k_data  out  8  kernel bus pixel value, equal to mem[k_addr]
- res_valid  in  1  collector result valid
- res_addr  in  bitSize+1  result pixel address
- res_data  in  8  result pixel value
- out_valid  out  1  final frame beat valid
- out_addr  out  bitSize+1  final frame beat address
- out_data  out  8  final frame beat value
- out_ready  in  1  downstream accepts out beat

## Operation
- States: IDLE, WRITE, READ, CHECK, DUMP.
- IDLE
  - load_ready=1.
  - Each load_valid beat writes mem[ld_ptr]; ld_ptr increments.
  - When the beat at N*N-1 is accepted, ld_ptr wraps to 0 and frame_loaded is set.
  - start with frame_loaded=1: clear iterations and changed, go to WRITE.
  - start with frame_loaded=0: ignored.
- WRITE
  - k_we=1; k_addr sweeps 0..N*N-1.
  - Each address is held for exactly 2 cycles, matching the kernels' alternate-cycle sampling. A phase bit toggles every cycle; the address advances when phase=1.
  - After address N*N-1, phase 1: go to READ, k_addr=0.
- READ
  - k_we=0; same 2-cycle sweep.
  - On each res_valid: if res_data != mem[res_addr], set changed. Then write mem[res_addr]=res_data.
  - After the sweep: go to CHECK.
- CHECK (1 cycle)
  - iterations+1, saturating at 255.
  - If changed=0 or the new count equals MAX_ITER: go to DUMP.
  - Otherwise: clear changed, go to WRITE.
- DUMP
  - out_valid=1, out_addr=ptr, out_data=mem[ptr].
  - ptr advances only on out_valid&out_ready.
  - When the beat at N*N-1 is accepted: done=1 for one cycle, busy=0, frame_loaded cleared, go to IDLE.
- Boundary and overlap behaviour:
  - res_valid outside READ is ignored.
  - load_valid outside IDLE is ignored (load_ready=0).
  - start outside IDLE is ignored.
  - A res_valid arriving on the last READ cycle is still written and compared.
  - If N*N is not a power of 2, all pointers compare against N*N-1 and never run past it.

## Timing
- Reset (async assert, sync release): state IDLE; load_ready=1 after release; all other outputs 0 (busy, done, iterations, k_we, k_addr, k_data, out_valid, out_addr, out_data); frame_loaded=0; ld_ptr=0. Memory contents are not reset.
- Reset mid-operation: abort immediately; a full frame must be reloaded before the next start.
- All outputs are registered.
- The edge that samples start also sets busy=1, k_we=1, k_addr=0, k_data=mem[0].
- WRITE lasts 2·N·N cycles, READ lasts 2·N·N cycles, CHECK lasts 1 cycle; one iteration is 4·N·N+1 cycles.
- k_data follows k_addr on the same edge.
- A result is written on the edge that samples res_valid and is visible in mem the next cycle.
- DUMP with out_ready held at 1: one beat per cycle, N·N cycles total. out_addr and out_data stay stable while out_ready=0.

## Structure
- Package skel_pkg:
  - state enum seq_state_t {IDLE, WRITE, READ, CHECK, DUMP}
  - PIX_W=8
  - function last_addr(N) returning N*N-1
- Sub-module frame_ram: N*N×8, one synchronous write port and two asynchronous read ports. Port A serves the k_data/out_data pointer; port B serves res_addr for the compare. Write-mux priority: load, then result.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release load_ready=1, busy=0.
- N=8, load 64×255, start -> k_addr 0..63 with each value held 2 cycles and k_data=255; collector echoes 255 -> iterations=1, 64 out beats of 255, then a single done pulse.
- Collector returns 0 at address 9 in iteration 1 and echoes in iteration 2 -> iterations=2, out_data at addr 9 is 0.
- MAX_ITER=3, collector toggles address 20 every iteration -> stops with iterations=3, busy length 3·257 cycles plus the DUMP cycles.
- out_ready low for 5 cycles at out_addr=10 -> out_addr=10 and out_data stay stable; no beat is skipped.
- rst_n pulsed during WRITE at k_addr=30 -> k_we=0 and busy=0 immediately; start ignored until 64 new pixels are loaded.
